// File: rtl/pcie_rx_byte_packer_pkg.sv
// Shared definitions for the PCIe RX byte packer: CONTROL codes, FSM encoding
// and the FIFO entry layout.
package pcie_rx_pkg;

    localparam logic [3:0] CTL_IDLE  = 4'd0;
    localparam logic [3:0] CTL_SYNC1 = 4'd1;
    localparam logic [3:0] CTL_SYNC2 = 4'd2;
    localparam logic [3:0] CTL_SYNC3 = 4'd3;
    localparam logic [3:0] CTL_SYNC4 = 4'd4;
    localparam logic [3:0] CTL_DATA  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC1  = 3'd1,
        ST_SYNC2  = 3'd2,
        ST_SYNC3  = 3'd3,
        ST_ACTIVE = 3'd4
    } state_t;

    typedef struct packed {
        logic        last;
        logic [3:0]  be;
        logic [31:0] data;
    } word_entry_t;

    localparam int ENTRY_W = $bits(word_entry_t);

    // Byte enables for a partial word holding idx bytes.
    function automatic logic [3:0] be_mask(input logic [1:0] idx);
        logic [3:0] m;
        case (idx)
            2'd0:    m = 4'b0000;
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            default: m = 4'b0111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pcie_rx_byte_packer_fifo.sv
// First-word-fall-through FIFO for packed word entries; a push on a full FIFO
// only succeeds when a pop happens on the same edge, otherwise it is dropped.
module pcie_rx_fifo
    import pcie_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output logic               drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && full && !pop_ok;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pcie_rx_byte_packer.sv
// PCIe RX byte packer: acquires framing from CONTROL 1,2,3,4 and packs data
// bytes LSB-first into 32-bit words. Optional checksum: PCIE_RX_CKSUM_EN.
//
// state     | meaning
// ST_IDLE   | waiting for CONTROL=1
// ST_SYNC1  | seen 1, expecting 2
// ST_SYNC2  | seen 1,2, expecting 3
// ST_SYNC3  | seen 1,2,3, expecting 4
// ST_ACTIVE | framed; CONTROL=9 bytes are packed, anything else closes the packet
module pcie_rx_byte_packer
    import pcie_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             CLK,
    input  logic             reset_L,
    input  logic [3:0]       CONTROL,
    input  logic [7:0]       DATA,
    input  logic             Valid,
    output logic [31:0]      word_out,
    output logic [3:0]       word_be,
    output logic             word_last,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             locked
`ifdef PCIE_RX_CKSUM_EN
    ,
    output logic [7:0]       cksum,
    output logic             cksum_valid
`endif
);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [23:0]        hold_q, hold_d;
    logic               any_push_q, any_push_d;
    logic               overflow_q, overflow_d;
    logic               push;
    word_entry_t        push_entry;
    word_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_raw;
    logic               fifo_full, fifo_empty, fifo_drop;
    state_t             restart;
    logic               eop;

    always_ff @(posedge CLK or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        restart = (CONTROL == CTL_SYNC1) ? ST_SYNC1 : ST_IDLE;
        state_d = state_q;
        if (Valid) begin
            case (state_q)
                ST_IDLE:   state_d = restart;
                ST_SYNC1:  state_d = (CONTROL == CTL_SYNC2) ? ST_SYNC2 : restart;
                ST_SYNC2:  state_d = (CONTROL == CTL_SYNC3) ? ST_SYNC3 : restart;
                ST_SYNC3:  state_d = (CONTROL == CTL_SYNC4) ? ST_ACTIVE : restart;
                ST_ACTIVE: state_d = (CONTROL == CTL_DATA) ? ST_ACTIVE : restart;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == ST_ACTIVE);
    end

    // Held bytes are zeroed whenever a word leaves, so unused lanes of a
    // partial word are already zero.
    always_comb begin
        idx_d      = idx_q;
        hold_d     = hold_q;
        any_push_d = any_push_q;
        push       = 1'b0;
        push_entry = '0;
        eop        = 1'b0;
        if (Valid && state_q == ST_ACTIVE) begin
            if (CONTROL == CTL_DATA) begin
                if (idx_q == 2'd3) begin
                    push            = 1'b1;
                    push_entry.data = {DATA, hold_q};
                    push_entry.be   = 4'b1111;
                    hold_d          = '0;
                    idx_d           = 2'd0;
                    any_push_d      = 1'b1;
                end else begin
                    case (idx_q)
                        2'd0:    hold_d[7:0]   = DATA;
                        2'd1:    hold_d[15:8]  = DATA;
                        default: hold_d[23:16] = DATA;
                    endcase
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                eop = 1'b1;
                if (idx_q != 2'd0) begin
                    push            = 1'b1;
                    push_entry.data = {8'h00, hold_q};
                    push_entry.be   = be_mask(idx_q);
                    push_entry.last = 1'b1;
                end else if (any_push_q) begin
                    push            = 1'b1;
                    push_entry.last = 1'b1;
                end
                idx_d      = 2'd0;
                hold_d     = '0;
                any_push_d = 1'b0;
            end
        end
        overflow_d = overflow_q | fifo_drop;
    end

    always_ff @(posedge CLK or negedge reset_L) begin
        if (!reset_L) begin
            idx_q      <= '0;
            hold_q     <= '0;
            any_push_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            any_push_q <= any_push_d;
            overflow_q <= overflow_d;
        end
    end

    pcie_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset_L),
        .push  (push),
        .din   (push_entry),
        .pop   (word_ready),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign head_entry = word_entry_t'(head_raw);
    assign word_out   = head_entry.data;
    assign word_be    = head_entry.be;
    assign word_last  = head_entry.last;
    assign word_valid = !fifo_empty;
    assign overflow   = overflow_q;

`ifdef PCIE_RX_CKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] cksum_q, cksum_d;
    logic       cksum_valid_q, cksum_valid_d;

    always_comb begin
        acc_d         = acc_q;
        cksum_d       = cksum_q;
        cksum_valid_d = 1'b0;
        if (Valid && state_q == ST_SYNC3 && CONTROL == CTL_SYNC4) begin
            acc_d = '0;
        end else if (Valid && state_q == ST_ACTIVE && CONTROL == CTL_DATA) begin
            acc_d = acc_q ^ DATA;
        end else if (eop) begin
            cksum_d       = acc_q;
            cksum_valid_d = 1'b1;
            acc_d         = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset_L) begin
        if (!reset_L) begin
            acc_q         <= '0;
            cksum_q       <= '0;
            cksum_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cksum_q       <= cksum_d;
            cksum_valid_q <= cksum_valid_d;
        end
    end

    assign cksum       = cksum_q;
    assign cksum_valid = cksum_valid_q;
`else
    logic unused_ok;
    assign unused_ok = eop ^ fifo_full;
`endif

endmodule

// File: tb/tb_pcie_rx_byte_packer.sv
// Self-checking bench for pcie_rx_byte_packer: directed scenarios plus a
// randomized stream, all compared against a queue-based reference model.
module tb_pcie_rx_byte_packer;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset_L;
    logic [3:0]  CONTROL;
    logic [7:0]  DATA;
    logic        Valid;
    logic        word_ready;
    logic [31:0] word_out;
    logic [3:0]  word_be;
    logic        word_last;
    logic        word_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        locked;
`ifdef PCIE_RX_CKSUM_EN
    logic [7:0]  cksum;
    logic        cksum_valid;
`endif

    pcie_rx_byte_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .CLK        (CLK),
        .reset_L    (reset_L),
        .CONTROL    (CONTROL),
        .DATA       (DATA),
        .Valid      (Valid),
        .word_out   (word_out),
        .word_be    (word_be),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .locked     (locked)
`ifdef PCIE_RX_CKSUM_EN
        ,
        .cksum      (cksum),
        .cksum_valid(cksum_valid)
`endif
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: sync progress as a count, bytes/words as queues
    int          sync_n;
    logic [7:0]  bq[$];
    logic [36:0] mq[$];
    bit          ovf_m;
    bit          pushed_any;
    logic [7:0]  pkt_bytes[$];
    logic [7:0]  ck_m;
    bit          ckv_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sync_n     = 0;
        bq.delete();
        mq.delete();
        ovf_m      = 0;
        pushed_any = 0;
        pkt_bytes.delete();
        ck_m       = 8'h00;
        ckv_m      = 0;
    endtask

    function automatic logic [36:0] make_word(input bit last);
        logic [31:0] d = 32'h0;
        logic [3:0]  be = 4'h0;
        for (int i = 0; i < bq.size(); i++) begin
            d     = d | (32'(bq[i]) << (8 * i));
            be[i] = 1'b1;
        end
        return {last, be, d};
    endfunction

    task automatic model_edge(input logic [3:0] c, input logic [7:0] d,
                              input logic v, input logic r);
        logic [36:0] new_w = '0;
        bit          do_push = 0;
        bit          pop_m;
        logic [7:0]  x;
        ckv_m = 0;
        pop_m = (mq.size() > 0) && r;
        if (v) begin
            if (sync_n == 4) begin
                if (c == 4'd9) begin
                    bq.push_back(d);
                    pkt_bytes.push_back(d);
                    if (bq.size() == 4) begin
                        new_w = make_word(0);
                        do_push = 1;
                        pushed_any = 1;
                        bq.delete();
                    end
                end else begin
                    if (bq.size() > 0) begin
                        new_w = make_word(1);
                        do_push = 1;
                    end else if (pushed_any) begin
                        new_w = {1'b1, 4'h0, 32'h0};
                        do_push = 1;
                    end
                    x = 8'h00;
                    foreach (pkt_bytes[i]) x = x ^ pkt_bytes[i];
                    ck_m  = x;
                    ckv_m = 1;
                    bq.delete();
                    pkt_bytes.delete();
                    pushed_any = 0;
                    sync_n = (c == 4'd1) ? 1 : 0;
                end
            end else if (int'(c) == sync_n + 1) begin
                sync_n++;
                if (sync_n == 4) begin
                    pkt_bytes.delete();
                    pushed_any = 0;
                end
            end else begin
                sync_n = (c == 4'd1) ? 1 : 0;
            end
        end
        if (pop_m) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(new_w);
            else ovf_m = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [36:0] h;
        chk({tag, ".valid"}, 64'(word_valid), 64'(mq.size() > 0));
        chk({tag, ".count"}, 64'(fifo_count), 64'(mq.size()));
        chk({tag, ".ovf"}, 64'(overflow), 64'(ovf_m));
        chk({tag, ".locked"}, 64'(locked), 64'(sync_n == 4));
        if (mq.size() > 0) begin
            h = mq[0];
            chk({tag, ".word"}, 64'(word_out), 64'(h[31:0]));
            chk({tag, ".be"}, 64'(word_be), 64'(h[35:32]));
            chk({tag, ".last"}, 64'(word_last), 64'(h[36]));
        end
`ifdef PCIE_RX_CKSUM_EN
        chk({tag, ".ckv"}, 64'(cksum_valid), 64'(ckv_m));
        if (ckv_m) chk({tag, ".ck"}, 64'(cksum), 64'(ck_m));
`endif
    endtask

    task automatic step(input logic [3:0] c, input logic [7:0] d, input logic v,
                        input logic r, input string tag);
        CONTROL    = c;
        DATA       = d;
        Valid      = v;
        word_ready = r;
        @(posedge CLK);
        model_edge(c, d, v, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        Valid = 1'b0; CONTROL = 4'd0; DATA = 8'h00; word_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.valid", 64'(word_valid), 64'd0);
        chk("rst.count", 64'(fifo_count), 64'd0);
        chk("rst.word", 64'(word_out), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.locked", 64'(locked), 64'd0);
        reset_L = 1'b1;
    endtask

    task automatic sync_up(input string tag);
        for (int i = 1; i <= 4; i++) step(4'(i), 8'h00, 1'b1, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) step(4'd0, 8'h00, 1'b0, 1'b1, tag);
    endtask

    initial begin
        logic [7:0] fw[4];
        logic [3:0] c;
        logic       r;
        fw[0] = 8'hAA; fw[1] = 8'hBB; fw[2] = 8'hCC; fw[3] = 8'hDD;

        do_reset();
        step(4'd0, 8'h00, 1'b1, 1'b0, "sync0");
        sync_up("sync");
        chk("sync.lock", 64'(locked), 64'd1);

        // full word followed by an end-of-packet zero word
        for (int i = 0; i < 4; i++) begin
            step(4'd9, fw[i], 1'b1, 1'b0, "full");
            if (i == 2) chk("full.lat_lo", 64'(word_valid), 64'd0);
        end
        chk("full.lat_hi", 64'(word_valid), 64'd1);
        chk("full.word", 64'(word_out), 64'hDDCCBBAA);
        step(4'd0, 8'h00, 1'b1, 1'b0, "full_eop");
        chk("full.cnt2", 64'(fifo_count), 64'd2);
`ifdef PCIE_RX_CKSUM_EN
        chk("full.ck", 64'(cksum), 64'h00);
`endif
        step(4'd0, 8'h00, 1'b0, 1'b1, "full_pop");
        chk("full.zlast", 64'(word_last), 64'd1);
        chk("full.zbe", 64'(word_be), 64'd0);
        drain("full_drain");

        // partial word
        sync_up("part_sync");
        step(4'd9, 8'h4F, 1'b1, 1'b0, "part");
        step(4'd9, 8'hA6, 1'b1, 1'b0, "part");
        step(4'd0, 8'h00, 1'b1, 1'b0, "part_eop");
        chk("part.word", 64'(word_out), 64'h0000A64F);
        chk("part.be", 64'(word_be), 64'h3);
        chk("part.last", 64'(word_last), 64'd1);
        chk("part.unlock", 64'(locked), 64'd0);
`ifdef PCIE_RX_CKSUM_EN
        chk("part.ck", 64'(cksum), 64'hE9);
        step(4'd0, 8'h00, 1'b0, 1'b0, "part_ckpulse");
        chk("part.ckv_lo", 64'(cksum_valid), 64'd0);
`endif
        drain("part_drain");

        // broken sync sequences
        step(4'd1, 8'h00, 1'b1, 1'b0, "brk");
        step(4'd2, 8'h00, 1'b1, 1'b0, "brk");
        step(4'd1, 8'h00, 1'b1, 1'b0, "brk");
        step(4'd2, 8'h00, 1'b1, 1'b0, "brk");
        step(4'd3, 8'h00, 1'b1, 1'b0, "brk");
        chk("brk.not_yet", 64'(locked), 64'd0);
        step(4'd4, 8'h00, 1'b1, 1'b0, "brk");
        chk("brk.lock", 64'(locked), 64'd1);
        step(4'd0, 8'h00, 1'b1, 1'b0, "brk_eop");
        chk("brk.empty_pkt", 64'(fifo_count), 64'd0);
        step(4'd1, 8'h00, 1'b1, 1'b0, "brk2");
        step(4'd3, 8'h00, 1'b1, 1'b0, "brk2");
        step(4'd4, 8'h00, 1'b1, 1'b0, "brk2");
        chk("brk2.idle", 64'(locked), 64'd0);

        // backpressure and overflow, then push+pop on a full FIFO
        sync_up("bp_sync");
        for (int i = 0; i < 20; i++) step(4'd9, 8'(8'h10 + i), 1'b1, 1'b0, "bp");
        chk("bp.count", 64'(fifo_count), 64'd4);
        chk("bp.ovf", 64'(overflow), 64'd1);
        chk("bp.head", 64'(word_out), 64'h13121110);
        for (int i = 0; i < 3; i++) step(4'd9, 8'(8'h80 + i), 1'b1, 1'b0, "bp_full");
        step(4'd9, 8'h83, 1'b1, 1'b1, "bp_pushpop");
        chk("bp.count_hold", 64'(fifo_count), 64'd4);
        chk("bp.head2", 64'(word_out), 64'h17161514);
        step(4'd0, 8'h00, 1'b1, 1'b0, "bp_eop");
        drain("bp_drain");

        // mid-packet reset discards held bytes and FIFO contents
        sync_up("mr_sync");
        for (int i = 0; i < 6; i++) step(4'd9, 8'(8'h30 + i), 1'b1, 1'b0, "mr");
        do_reset();
        sync_up("mr_resync");
        step(4'd0, 8'h00, 1'b1, 1'b0, "mr_eop");
        chk("mr.count", 64'(fifo_count), 64'd0);

        // randomized stream
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 99);
            if (sync_n == 4)      c = (sel < 85) ? 4'd9 : ((sel < 92) ? 4'd1 : 4'($urandom_range(0, 15)));
            else if (sel < 70)    c = 4'(sync_n + 1);
            else if (sel < 85)    c = 4'd1;
            else                  c = 4'($urandom_range(0, 15));
            r = ((i % 200) < 60) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            step(c, 8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0, r, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
